// File: rtl/bist_pkg.sv
// bist_pkg: March C- states, per-element operation table and error counter width
package bist_pkg;
  localparam int ERR_W = 16;
  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_FIN
  } state_e;
  typedef struct packed {
    logic desc;
    logic rd;
    logic wr;
    logic rbg;
    logic wbg;
  } elem_t;
  // fields: descending, has read, has write, read background, write background
  localparam elem_t ELEM [16] = '{
    5'b00000, 5'b00100, 5'b01101, 5'b01110,
    5'b11101, 5'b11110, 5'b11000, 5'b00000,
    5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b00000, 5'b00000, 5'b00000, 5'b00000
  };
  function automatic logic is_op(state_e s);
    return s >= S_M0 && s <= S_M5;
  endfunction
endpackage

// File: rtl/bist_exp_pipe.sv
// bist_exp_pipe: RLAT-deep delay line of {valid, expected data, address} for read compares
module bist_exp_pipe
  import bist_pkg::*;
#(
  parameter int RLAT   = 1,
  parameter int RWIDTH = 34,
  parameter int RDEPTH = 14
) (
  input  logic              CLK_i,
  input  logic              RSTn_i,
  input  logic              clr_i,
  input  logic              v_i,
  input  logic [RWIDTH-1:0] exp_i,
  input  logic [RDEPTH-1:0] addr_i,
  output logic              v_o,
  output logic [RWIDTH-1:0] exp_o,
  output logic [RDEPTH-1:0] addr_o
);
  logic [RLAT-1:0]   v_q;
  logic [RWIDTH-1:0] e_q [RLAT];
  logic [RDEPTH-1:0] a_q [RLAT];
  // shift one stage per cycle; a clear drops every in-flight valid bit
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      v_q <= '0;
      for (int k = 0; k < RLAT; k++) begin
        e_q[k] <= '0;
        a_q[k] <= '0;
      end
    end else begin
      v_q[0] <= v_i & ~clr_i;
      e_q[0] <= exp_i;
      a_q[0] <= addr_i;
      for (int k = 1; k < RLAT; k++) begin
        v_q[k] <= v_q[k-1] & ~clr_i;
        e_q[k] <= e_q[k-1];
        a_q[k] <= a_q[k-1];
      end
    end
  end
  assign v_o    = v_q[RLAT-1];
  assign exp_o  = e_q[RLAT-1];
  assign addr_o = a_q[RLAT-1];
endmodule

// File: rtl/march_bist_gen.sv
// march_bist_gen: March C- address/data generator with delayed read compare and error capture
module march_bist_gen
  import bist_pkg::*;
#(
  parameter int RWIDTH = 34,
  parameter int RDEPTH = 14,
  parameter int RLAT   = 1
) (
  input  logic              CLK_i,
  input  logic              RSTn_i,
  input  logic              START_i,
  input  logic [RWIDTH-1:0] Q_i,
  output logic [RWIDTH-1:0] I_o,
  output logic [RDEPTH-1:0] IA_o,
  output logic              WE_o,
  output logic              BUSY_o,
  output logic              DONE_o,
  output logic              FAIL_o,
  output logic [RDEPTH-1:0] FAIL_ADDR_o,
  output logic [ERR_W-1:0]  ERR_CNT_o
);
  localparam logic [RDEPTH-1:0] AMAX = '1;
  state_e            state_q, state_d;
  logic [RDEPTH-1:0] addr_q, addr_d, ia_q, ia_d, faddr_q, faddr_d, pa;
  logic [RWIDTH-1:0] i_q, i_d, pe;
  logic [ERR_W-1:0]  ecnt_q, ecnt_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic              ph_q, ph_d, we_q, we_d, rv_q, rv_d, busy_q, busy_d, done_q, done_d;
  logic              fail_q, fail_d, start, two, last, op_d, pv, miss;
  assign start = START_i & (state_q == S_IDLE | state_q == S_FIN);
  assign two   = ELEM[state_q].rd & ELEM[state_q].wr;
  assign last  = (ELEM[state_q].desc ? addr_q == '0 : addr_q == AMAX) & (ph_q | ~two);
  assign miss  = pv & (Q_i != pe);
  // sequencing: ph_q selects the write half of a read/write pair at one address
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    dcnt_d  = dcnt_q;
    if (start) begin
      state_d = S_M0;
      addr_d  = '0;
      ph_d    = 1'b0;
    end else if (state_q == S_DRAIN) begin
      dcnt_d = dcnt_q + 3'd1;
      if (dcnt_q == 3'(RLAT - 1)) state_d = S_FIN;
    end else if (is_op(state_q)) begin
      if (last) begin
        state_d = state_e'(state_q + 4'd1);
        addr_d  = ELEM[state_q + 4'd1].desc ? AMAX : '0;
        ph_d    = 1'b0;
        dcnt_d  = '0;
      end else if (two & ~ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d   = 1'b0;
        addr_d = ELEM[state_q].desc ? addr_q - 1'b1 : addr_q + 1'b1;
      end
    end
  end
  // memory-side outputs decoded from the next operation so they leave registered
  always_comb begin
    op_d   = is_op(state_d);
    we_d   = op_d & ELEM[state_d].wr & (ph_d | ~ELEM[state_d].rd);
    rv_d   = op_d & ~we_d;
    i_d    = op_d ? {RWIDTH{we_d ? ELEM[state_d].wbg : ELEM[state_d].rbg}} : '0;
    ia_d   = op_d ? addr_d : '0;
    busy_d = op_d | state_d == S_DRAIN;
    done_d = state_d == S_FIN;
  end
  // result capture; an accepted start wins over a simultaneous miscompare
  always_comb begin
    fail_d  = fail_q;
    faddr_d = faddr_q;
    ecnt_d  = ecnt_q;
    if (start) begin
      fail_d  = 1'b0;
      faddr_d = '0;
      ecnt_d  = '0;
    end else if (miss) begin
      fail_d  = 1'b1;
      faddr_d = fail_q ? faddr_q : pa;
      ecnt_d  = ecnt_q == '1 ? ecnt_q : ecnt_q + 1'b1;
    end
  end
  // all state and output registers
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      dcnt_q  <= '0;
      i_q     <= '0;
      ia_q    <= '0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      dcnt_q  <= dcnt_d;
      i_q     <= i_d;
      ia_q    <= ia_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      ecnt_q  <= ecnt_d;
    end
  end
  bist_exp_pipe #(.RLAT(RLAT), .RWIDTH(RWIDTH), .RDEPTH(RDEPTH)) u_pipe (
    .CLK_i  (CLK_i),
    .RSTn_i (RSTn_i),
    .clr_i  (start),
    .v_i    (rv_q),
    .exp_i  (i_q),
    .addr_i (ia_q),
    .v_o    (pv),
    .exp_o  (pe),
    .addr_o (pa)
  );
  assign I_o         = i_q;
  assign IA_o        = ia_q;
  assign WE_o        = we_q;
  assign BUSY_o      = busy_q;
  assign DONE_o      = done_q;
  assign FAIL_o      = fail_q;
  assign FAIL_ADDR_o = faddr_q;
  assign ERR_CNT_o   = ecnt_q;
endmodule

// File: doc/march_bist_gen.md
MARCH_BIST_GEN -- requirements
Module: march_bist_gen

Interface
- REQ-001: The block SHALL have the following parameters (name, default, meaning):
  - RWIDTH, 34: memory data width.
  - RDEPTH, 14: address width; the test covers N = 2^RDEPTH words.
  - RLAT, 1: memory read latency in cycles, legal range 1..4.
- REQ-002: The block SHALL have the following ports (name, direction, width, meaning):
  - CLK_i, input, 1: the single clock; all logic is rising-edge.
  - RSTn_i, input, 1: asynchronous, active-low reset.
  - START_i, input, 1: one-cycle test request.
  - Q_i, input, RWIDTH: memory read data.
  - I_o, output, RWIDTH: write data to the memory-side delay stage.
  - IA_o, output, RDEPTH: address to the memory-side delay stage.
  - WE_o, output, 1: write enable; 1 = write, 0 = read.
  - BUSY_o, output, 1: test in progress.
  - DONE_o, output, 1: test complete; level signal.
  - FAIL_o, output, 1: sticky miscompare flag.
  - FAIL_ADDR_o, output, RDEPTH: address of the first miscompare.
  - ERR_CNT_o, output, 16: saturating miscompare count.

Function
- REQ-003: The block SHALL run March C- on N words. Background B0 = all zeros, B1 = all ones. The elements are:
  - M0: ascending, w0.
  - M1: ascending, r0 then w1.
  - M2: ascending, r1 then w0.
  - M3: descending, r0 then w1.
  - M4: descending, r1 then w0.
  - M5: descending, r0.
- REQ-004: The FSM states SHALL be IDLE, M0, M1, M2, M3, M4, M5, DRAIN and FIN. Transitions:
  - IDLE -> M0 on START_i.
  - Mk -> Mk+1 after the last operation at the terminal address (N-1 ascending, 0 descending).
  - M5 -> DRAIN.
  - DRAIN -> FIN after RLAT cycles.
  - FIN -> M0 on START_i.
- REQ-005: Exactly one memory operation SHALL issue per cycle while in M0..M5. Read and write at the same address occupy consecutive cycles. The total operation count is 10N cycles.
- REQ-006: Ascending elements SHALL start at address 0 and descending elements at N-1. The address counter SHALL NOT wrap between elements; it reloads at each element start.
- REQ-007: Read cycles SHALL drive WE_o=0 with I_o equal to the expected background. Write cycles SHALL drive WE_o=1 with I_o equal to the write background.
- REQ-008: Outputs SHALL be registered. In IDLE, DRAIN and FIN: WE_o=0, IA_o=0, I_o=0.
- REQ-009: Each read SHALL push {valid, expected, address} into an RLAT-deep pipeline. Q_i SHALL be compared against the pipeline output exactly RLAT cycles after the read cycle.
- REQ-010: On a miscompare:
  - FAIL_o sets and stays set.
  - FAIL_ADDR_o captures the address only on the first miscompare of the run.
  - ERR_CNT_o increments, saturating at 16'hFFFF.
- REQ-011: BUSY_o SHALL be 1 in M0..DRAIN. DONE_o SHALL be 1 in FIN only.
- REQ-012: START_i SHALL be ignored while BUSY_o=1.
- REQ-013: START_i accepted from IDLE or FIN SHALL clear FAIL_o, FAIL_ADDR_o, ERR_CNT_o and the pipeline valid bits in the same cycle. The first operation SHALL appear on the outputs in the following cycle.
- REQ-014: Comparisons for reads issued in M5 SHALL complete during DRAIN, before DONE_o rises.
- REQ-015: A miscompare and START_i in the same cycle while in FIN SHALL resolve to the clear.

Reset
- REQ-016: RSTn_i low SHALL asynchronously force:
  - state = IDLE;
  - all outputs = 0;
  - address counter and pipeline valid bits = 0.
- REQ-017: Deassertion of RSTn_i SHALL be sampled synchronously. Reset mid-test SHALL abort the run with no further writes issued.

Structure
- REQ-018: The state encoding, the element direction/operation table, and the error counter width (16) SHALL reside in the shared package bist_pkg.
- REQ-019: The expected-data/address delay line SHALL be one sub-module, bist_exp_pipe, parameterised by RLAT, RWIDTH and RDEPTH.
- REQ-020: No memory model SHALL be instantiated inside the block.

Verification
All scenarios use RDEPTH=3 (N=8) and RLAT=1 unless stated otherwise.
- REQ-021: Clean run. Stimulus: START_i pulse with a correct memory model. Required response: BUSY_o high for 80+1 cycles, DONE_o=1, FAIL_o=0, ERR_CNT_o=0.
- REQ-022: Stuck-at-1. Stimulus: stuck-at-1 on bit 0 at address 5. Required response: FAIL_o=1, FAIL_ADDR_o=5, ERR_CNT_o=3 (M1, M3 and M5 r0 fail).
- REQ-023: Operation sequence. Stimulus: monitor IA_o/WE_o sequence through M0 and M3. Required response: M0 shows 0..7 with WE_o=1. M3 shows 7,7,6,6,...,0,0 with WE_o alternating 0,1.
- REQ-024: RLAT=3 drain. Stimulus: RLAT=3 with a fault at address 0 in M5 only. Required response: miscompare counted before DONE_o rises; DRAIN lasts 3 cycles.
- REQ-025: Reset mid-test. Stimulus: RSTn_i asserted mid-M2. Required response: all outputs 0 immediately; a subsequent START_i runs a full clean test.
- REQ-026: START_i while busy. Stimulus: START_i pulse while BUSY_o=1. Required response: ignored; the cycle count is unchanged.
